// File: rtl/demux_custom_reg_pkg.sv
// Shared constants for the 3-bank write demux: select codes, bank indices and FSM states.
// The select codes match the read-side selector so a word written with sel=s reads back with s.
package demux_custom_reg_pkg;

    localparam int unsigned WORD_W    = 8;
    localparam int unsigned NUM_BANKS = 3;

    localparam logic [1:0] SEL_A     = 2'b01;
    localparam logic [1:0] SEL_B     = 2'b10;
    localparam logic [1:0] SEL_C     = 2'b11;
    localparam logic [1:0] SEL_C_ALT = 2'b00;

    localparam int unsigned BANK_A = 0;
    localparam int unsigned BANK_B = 1;
    localparam int unsigned BANK_C = 2;

    typedef enum logic {
        StIdle = 1'b0,
        StDone = 1'b1
    } state_e;

    // One-hot bank mask for a select code; 00 and 11 both address C.
    function automatic logic [NUM_BANKS-1:0] sel_to_mask(input logic [1:0] s);
        logic [NUM_BANKS-1:0] m;
        m = '0;
        case (s)
            SEL_A:   m[BANK_A] = 1'b1;
            SEL_B:   m[BANK_B] = 1'b1;
            default: m[BANK_C] = 1'b1;
        endcase
        return m;
    endfunction

    function automatic logic [1:0] ptr_advance(input logic [1:0] p);
        logic [1:0] n;
        case (p)
            SEL_A:   n = SEL_B;
            SEL_B:   n = SEL_C;
            default: n = SEL_A;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/demux_custom_reg_reg8_en.sv
// 8-bit storage register with synchronous reset, synchronous clear and load enable.
// Reset and clear both win over load.
module reg8_en
    import demux_custom_reg_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic [WORD_W-1:0] d_i,
    output logic [WORD_W-1:0] q_o
);

    logic [WORD_W-1:0] q_d, q_q;

    always_comb begin
        q_d = q_q;
        if (clear_i) begin
            q_d = '0;
        end else if (load_i) begin
            q_d = d_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/demux_custom_reg.sv
// Write-side demux: stores an input word into bank A, B or C (manual sel or round-robin pointer)
// and exposes the banks as the 24 interleaved lanes the selector reads.
module demux_custom_reg
    import demux_custom_reg_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic [1:0]       sel,
    input  logic             auto,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic             clear,
    output logic [1:0]       ptr,
    output logic [2:0]       word_valid,
    output logic             frame_done,
    output logic data_out_1,  output logic data_out_2,  output logic data_out_3,
    output logic data_out_4,  output logic data_out_5,  output logic data_out_6,
    output logic data_out_7,  output logic data_out_8,  output logic data_out_9,
    output logic data_out_10, output logic data_out_11, output logic data_out_12,
    output logic data_out_13, output logic data_out_14, output logic data_out_15,
    output logic data_out_16, output logic data_out_17, output logic data_out_18,
    output logic data_out_19, output logic data_out_20, output logic data_out_21,
    output logic data_out_22, output logic data_out_23, output logic data_out_24
);

    state_e               state_d, state_q;
    logic [1:0]           ptr_d, ptr_q;
    logic [2:0]           valid_d, valid_q;
    logic [NUM_BANKS-1:0] load;
    logic [NUM_BANKS-1:0] tgt_mask;
    logic                 wr_fire;
    logic [WIDTH-1:0]     bank_a, bank_b, bank_c;

    assign wr_ready   = (state_q == StIdle);
    assign frame_done = (state_q == StDone);
    assign wr_fire    = wr_valid & wr_ready;
    assign tgt_mask   = sel_to_mask(auto ? ptr_q : sel);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        valid_d = valid_q;
        load    = '0;
        unique case (state_q)
            StIdle: begin
                if (wr_fire) begin
                    load    = tgt_mask;
                    valid_d = valid_q | tgt_mask;
                    if (auto) begin
                        ptr_d = ptr_advance(ptr_q);
                    end
                    if (valid_d == 3'b111) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                valid_d = '0;
                ptr_d   = SEL_A;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Clear discards any write this cycle; DONE still reports its pulse.
        if (clear) begin
            valid_d = '0;
            ptr_d   = SEL_A;
            load    = '0;
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            ptr_q   <= SEL_A;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
        end
    end

    assign ptr        = ptr_q;
    assign word_valid = valid_q;

    reg8_en u_bank_a (
        .clk_i   (clk),
        .reset_i (reset),
        .clear_i (clear),
        .load_i  (load[BANK_A]),
        .d_i     (data_in),
        .q_o     (bank_a)
    );

    reg8_en u_bank_b (
        .clk_i   (clk),
        .reset_i (reset),
        .clear_i (clear),
        .load_i  (load[BANK_B]),
        .d_i     (data_in),
        .q_o     (bank_b)
    );

    reg8_en u_bank_c (
        .clk_i   (clk),
        .reset_i (reset),
        .clear_i (clear),
        .load_i  (load[BANK_C]),
        .d_i     (data_in),
        .q_o     (bank_c)
    );

    assign data_out_1  = bank_a[0];
    assign data_out_2  = bank_b[0];
    assign data_out_3  = bank_c[0];
    assign data_out_4  = bank_a[1];
    assign data_out_5  = bank_b[1];
    assign data_out_6  = bank_c[1];
    assign data_out_7  = bank_a[2];
    assign data_out_8  = bank_b[2];
    assign data_out_9  = bank_c[2];
    assign data_out_10 = bank_a[3];
    assign data_out_11 = bank_b[3];
    assign data_out_12 = bank_c[3];
    assign data_out_13 = bank_a[4];
    assign data_out_14 = bank_b[4];
    assign data_out_15 = bank_c[4];
    assign data_out_16 = bank_a[5];
    assign data_out_17 = bank_b[5];
    assign data_out_18 = bank_c[5];
    assign data_out_19 = bank_a[6];
    assign data_out_20 = bank_b[6];
    assign data_out_21 = bank_c[6];
    assign data_out_22 = bank_a[7];
    assign data_out_23 = bank_b[7];
    assign data_out_24 = bank_c[7];

endmodule

// File: tb/tb_demux_custom_reg.sv
// Directed bench for demux_custom_reg: reset, manual and auto frames, clear, overwrite,
// selector loopback and mid-frame reset, all against hand-computed values.
module tb_demux_custom_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  data_in;
    logic [1:0]  sel;
    logic        auto;
    logic        wr_valid;
    logic        wr_ready;
    logic        clear;
    logic [1:0]  ptr;
    logic [2:0]  word_valid;
    logic        frame_done;
    logic [23:0] flat;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    demux_custom_reg #(.WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .sel        (sel),
        .auto       (auto),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .clear      (clear),
        .ptr        (ptr),
        .word_valid (word_valid),
        .frame_done (frame_done),
        .data_out_1 (flat[0]),  .data_out_2 (flat[1]),  .data_out_3 (flat[2]),
        .data_out_4 (flat[3]),  .data_out_5 (flat[4]),  .data_out_6 (flat[5]),
        .data_out_7 (flat[6]),  .data_out_8 (flat[7]),  .data_out_9 (flat[8]),
        .data_out_10(flat[9]),  .data_out_11(flat[10]), .data_out_12(flat[11]),
        .data_out_13(flat[12]), .data_out_14(flat[13]), .data_out_15(flat[14]),
        .data_out_16(flat[15]), .data_out_17(flat[16]), .data_out_18(flat[17]),
        .data_out_19(flat[18]), .data_out_20(flat[19]), .data_out_21(flat[20]),
        .data_out_22(flat[21]), .data_out_23(flat[22]), .data_out_24(flat[23])
    );

    task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Selector model: lane k of the read word comes from data_out_(3k+j+1).
    function automatic logic [7:0] sel_read(input logic [23:0] f, input logic [1:0] s);
        logic [7:0] r;
        int j;
        j = (s == 2'b01) ? 0 : (s == 2'b10) ? 1 : 2;
        for (int k = 0; k < 8; k++) r[k] = f[3*k+j];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_one(input logic [7:0] d, input logic [1:0] s);
        wr_valid = 1'b1;
        data_in  = d;
        sel      = s;
        step();
        wr_valid = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        wr_valid = 1'b1;
        data_in  = 8'hFF;
        sel      = 2'b01;
        auto     = 1'b0;
        clear    = 1'b0;
        step();
        step();
        check("rst_flat", flat, 24'h0);
        check("rst_wv", {21'd0, word_valid}, 24'd0);
        check("rst_ptr", {22'd0, ptr}, 24'd1);
        check("rst_fd", {23'd0, frame_done}, 24'd0);

        reset    = 1'b0;
        wr_valid = 1'b0;
        step();
        check("rel_ready", {23'd0, wr_ready}, 24'd1);
        check("rel_flat", flat, 24'h0);

        // Manual frame A5/3C/0F.
        write_one(8'hA5, 2'b01);
        check("man_wv1", {21'd0, word_valid}, 24'b001);
        check("man_fd1", {23'd0, frame_done}, 24'd0);
        write_one(8'h3C, 2'b10);
        write_one(8'h0F, 2'b00);
        check("man_a", {16'd0, sel_read(flat, 2'b01)}, 24'hA5);
        check("man_b", {16'd0, sel_read(flat, 2'b10)}, 24'h3C);
        check("man_c", {16'd0, sel_read(flat, 2'b11)}, 24'h0F);
        check("man_lane1", {23'd0, flat[0]}, 24'd1);
        check("man_lane22", {23'd0, flat[21]}, 24'd1);
        check("man_fd", {23'd0, frame_done}, 24'd1);
        check("man_ready", {23'd0, wr_ready}, 24'd0);
        check("man_wv", {21'd0, word_valid}, 24'b111);
        check("man_ptr_hold", {22'd0, ptr}, 24'd1);
        step();
        check("man_fd_end", {23'd0, frame_done}, 24'd0);
        check("man_wv_end", {21'd0, word_valid}, 24'b000);
        check("man_ready_end", {23'd0, wr_ready}, 24'd1);

        // Auto mode: 11,22,33 fill A,B,C; 44 stalls through DONE then lands in A.
        auto     = 1'b1;
        wr_valid = 1'b1;
        sel      = 2'b10;
        data_in  = 8'h11;
        step();
        check("auto_ptr1", {22'd0, ptr}, 24'b10);
        check("auto_wv1", {21'd0, word_valid}, 24'b001);
        data_in = 8'h22;
        step();
        check("auto_ptr2", {22'd0, ptr}, 24'b11);
        data_in = 8'h33;
        step();
        check("auto_fd", {23'd0, frame_done}, 24'd1);
        check("auto_ready", {23'd0, wr_ready}, 24'd0);
        check("auto_a", {16'd0, sel_read(flat, 2'b01)}, 24'h11);
        check("auto_b", {16'd0, sel_read(flat, 2'b10)}, 24'h22);
        check("auto_c", {16'd0, sel_read(flat, 2'b00)}, 24'h33);
        data_in = 8'h44;
        step();
        check("stall_a", {16'd0, sel_read(flat, 2'b01)}, 24'h11);
        check("stall_fd", {23'd0, frame_done}, 24'd0);
        check("stall_wv", {21'd0, word_valid}, 24'b000);
        check("stall_ptr", {22'd0, ptr}, 24'b01);
        step();
        wr_valid = 1'b0;
        check("auto44_a", {16'd0, sel_read(flat, 2'b01)}, 24'h44);
        check("auto44_ptr", {22'd0, ptr}, 24'b10);
        check("auto44_wv", {21'd0, word_valid}, 24'b001);
        check("auto44_b", {16'd0, sel_read(flat, 2'b10)}, 24'h22);

        // Clear with a concurrent write: everything zeroed, write discarded.
        auto     = 1'b0;
        clear    = 1'b1;
        wr_valid = 1'b1;
        data_in  = 8'h77;
        sel      = 2'b01;
        step();
        clear    = 1'b0;
        wr_valid = 1'b0;
        check("clr_flat", flat, 24'h0);
        check("clr_wv", {21'd0, word_valid}, 24'b000);
        check("clr_ptr", {22'd0, ptr}, 24'b01);

        // Overwrite C twice.
        write_one(8'h01, 2'b11);
        write_one(8'h02, 2'b11);
        check("ovr_c", {16'd0, sel_read(flat, 2'b11)}, 24'h02);
        check("ovr_wv", {21'd0, word_valid}, 24'b100);
        check("ovr_fd", {23'd0, frame_done}, 24'd0);

        // Complete the frame and read back through the selector model.
        write_one(8'h5A, 2'b01);
        write_one(8'hC3, 2'b10);
        check("lb_fd", {23'd0, frame_done}, 24'd1);
        check("lb_sel00", {16'd0, sel_read(flat, 2'b00)}, 24'h02);
        check("lb_sel01", {16'd0, sel_read(flat, 2'b01)}, 24'h5A);
        check("lb_sel10", {16'd0, sel_read(flat, 2'b10)}, 24'hC3);
        check("lb_sel11", {16'd0, sel_read(flat, 2'b11)}, 24'h02);

        // Reset while in DONE.
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mrst_flat", flat, 24'h0);
        check("mrst_fd", {23'd0, frame_done}, 24'd0);
        check("mrst_ready", {23'd0, wr_ready}, 24'd1);
        check("mrst_wv", {21'd0, word_valid}, 24'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demux_custom_reg.md
Name: demux_custom_reg

Overview:
- Write-side counterpart of the 3-word, 8-bit selector: routes an 8-bit input word into one of three registered 8-bit word banks (A, B, C) and presents them as 24 flat bits laid out exactly as the selector consumes them.
- Supports a manual mode (word chosen by `sel`) and an auto mode (internal round-robin pointer A→B→C).
- Uses a valid/ready write handshake and flags when a full A/B/C frame has been written.
- Sits upstream of the selector in the display/data path.

Parameters:
- WIDTH, 8, bits per word; fixed at 8 for compatibility with the selector's eight output lanes.

Ports:
- clk  input  1  single system clock, rising edge
- reset  input  1  synchronous, active-high; sampled only on rising clk
- data_in  input  8  word to store; bit k feeds output lane k+1
- sel  input  2  manual target: 2'b01=A, 2'b10=B, 2'b00 or 2'b11=C
- auto  input  1  1 = ignore sel, use the internal pointer
- wr_valid  input  1  write request
- wr_ready  output  1  1 when a write can be accepted this cycle
- clear  input  1  synchronous clear of all banks, flags and pointer
- ptr  output  2  current auto pointer, encoded as for sel (01 A, 10 B, 11 C)
- word_valid  output  3  bit0 A, bit1 B, bit2 C written since last clear/frame
- frame_done  output  1  one-cycle pulse when A, B and C are all valid
- data_out_1 .. data_out_24  output  1 each  flat bank image: data_out_(3k+1)=A[k], data_out_(3k+2)=B[k], data_out_(3k+3)=C[k], k=0..7

Behaviour:
- Reset (reset=1 at a clk edge) drives all of the following:
  - A=B=C=8'h00, so every data_out_n=0.
  - word_valid=3'b000, frame_done=0, ptr=2'b01.
  - FSM state=IDLE, so wr_ready=1 from the first cycle after reset deasserts.
- Reset has priority over clear; clear has priority over writes.
- Accepted write: wr_valid & wr_ready at a rising edge.
  - Target = ptr if auto=1, else decoded sel.
  - The target bank loads data_in; new value is visible on data_out the next cycle (1-cycle latency).
  - The target's word_valid bit is set.
- Auto pointer: advances on each accepted write with auto=1, 01→10→11→01 (wraps after C). Holds on manual writes.
- FSM states:
  - IDLE: wr_ready=1. Accepted write → IDLE, unless the write makes word_valid==3'b111 → DONE.
  - DONE: lasts one cycle.
    - frame_done=1, wr_ready=0.
    - word_valid cleared to 000 and ptr reset to 01 at exit.
    - Unconditionally → IDLE.
    - Banks retain their data.
- Overwrites: rewriting an already-valid bank before the frame completes is allowed; the data is replaced and no flag changes.
- clear in DONE: flags and pointer still cleared, banks zeroed, frame_done still pulses this cycle.
- wr_valid while wr_ready=0: ignored, no side effects. The source must hold data until accepted.
- Mid-operation reset: any state → IDLE with the reset values above; the next edge is a normal IDLE cycle.
- Mapping note: sel=00 and sel=11 both target C, matching the selector's read mapping, so a write with sel=s reads back through the selector with the same sel.
- No combinational path from data_in to data_out. wr_ready depends only on state.

Decomposition:
- Shared package constants:
  - SEL_A=2'b01, SEL_B=2'b10, SEL_C=2'b11, SEL_C_ALT=2'b00.
  - Bank index constants.
  - FSM state encodings IDLE/DONE.
- One natural sub-module: reg8_en (8-bit register with synchronous reset, synchronous clear and load enable), instantiated three times for A, B, C.
- Pointer, flags and FSM stay in the top.

Test Plan:
- Reset: hold reset 2 cycles with wr_valid=1, data_in=8'hFF → all data_out_n=0, word_valid=000, ptr=01, frame_done=0. Release → wr_ready=1 next cycle.
- Manual writes: auto=0; write 8'hA5 sel=01, 8'h3C sel=10, 8'h0F sel=00.
  - Cycle after the third write: data_out_1,4,...,22 = A5 bits; data_out_2,5,... = 3C bits; data_out_3,6,... = 0F bits.
  - frame_done pulses for one cycle with wr_ready=0, then word_valid=000.
- Auto wrap: auto=1, four back-to-back writes 11,22,33,44 with wr_valid held.
  - A=11, B=22, C=33; frame_done pulses after 33.
  - 44 is stalled one cycle (DONE), then stored in A with ptr 01→10.
- Overwrite: manual writes 8'h01 then 8'h02 to sel=11 → C=02, word_valid=100, no frame_done.
- Clear: banks loaded, assert clear together with wr_valid → all data_out=0, word_valid=000, ptr=01, write discarded.
- Loopback: selector driven by this block's outputs, sel=00/01/10/11 → reads C/A/B/C respectively, matching the written words.
